// File: rtl/filter_cfg_pkg.sv
// filter_cfg_pkg
//   Shared definitions for the filter configuration controller:
//   - cfg_state_e     : controller FSM state (IDLE / ARMED)
//   - identity_kernel : flat identity kernel (centre coefficient = 1),
//                       returned at a fixed maximum width; callers keep
//                       the low FILTER_DIM*FILTER_DIM*COE_WIDTH bits.
package filter_cfg_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } cfg_state_e;

  // Largest kernel the helper can describe: 7x7 taps of up to 16 bits.
  localparam int MAX_DIM       = 7;
  localparam int MAX_COE_WIDTH = 16;
  localparam int MAX_FLAT      = MAX_DIM * MAX_DIM * MAX_COE_WIDTH;

  // Coefficient index (dim*dim-1)/2 is the kernel centre; its value is 1,
  // so only the LSB of that slot is set.
  function automatic logic [MAX_FLAT-1:0] identity_kernel(input int dim, input int coe_width);
    logic [MAX_FLAT-1:0] k;
    k = {{(MAX_FLAT-1){1'b0}}, 1'b1} << (((dim * dim - 1) / 2) * coe_width);
    return k;
  endfunction

endpackage

// File: rtl/coef_bank.sv
// coef_bank
//   DEPTH x COE_WIDTH coefficient register file.
//   Ports:
//     clk, reset            : clock, async active-high reset (to RESET_VAL)
//     wr_en/wr_addr/wr_data : single write port; addresses >= DEPTH are dropped
//     load_en/load_data     : whole-bank load from a flat vector (wins over write)
//     rd_data               : flat parallel read, entry 0 in the LSBs
module coef_bank #(
  parameter int DEPTH      = 9,
  parameter int COE_WIDTH  = 8,
  parameter int ADDR_WIDTH = 4,
  parameter logic [DEPTH*COE_WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [COE_WIDTH-1:0]         wr_data,
  input  logic                         load_en,
  input  logic [DEPTH*COE_WIDTH-1:0]   load_data,
  output logic [DEPTH*COE_WIDTH-1:0]   rd_data
);

  logic [DEPTH*COE_WIDTH-1:0] mem_q, mem_d;

  always_comb begin
    mem_d = mem_q;
    if (load_en) begin
      mem_d = load_data;
    end else if (wr_en) begin
      // Out-of-range addresses match no entry and are silently dropped.
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_addr == ADDR_WIDTH'(i)) begin
          mem_d[i*COE_WIDTH +: COE_WIDTH] = wr_data;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q <= RESET_VAL;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data = mem_q;

endmodule

// File: rtl/filter_cfg_ctrl.sv
// filter_cfg_ctrl
//   Runtime kernel configuration for stream_video_filter. Coefficient
//   writes land in a shadow bank; a commit arms a swap that copies the
//   shadow bank (and norm) into the active bank on the next SOF beat of
//   the filter's input stream, so a frame never sees mixed kernels.
//   Ports:
//     clk, reset                      : clock, async active-high reset
//     cfg_wr_valid/ready/addr/data    : coefficient write channel
//     cfg_norm, cfg_commit, cfg_abort : arm (capturing norm) / cancel a swap
//     vid_tvalid/tready/tuser         : monitored taps of the filter input
//     coef_active, norm_active        : active kernel (flat) and shift
//     cfg_pending                     : high while a swap is armed
//     swap_pulse                      : one cycle after each swap edge
//     err_addr                        : sticky out-of-range write flag
//     frame_cnt                       : count of SOF beats (wraps)
//
//   Write handshake: a write transfers on any rising edge where
//   cfg_wr_valid && cfg_wr_ready. cfg_wr_ready depends only on the FSM
//   state (high in IDLE), never on cfg_wr_valid; the master holds
//   addr/data stable while valid is high and not yet accepted.
module filter_cfg_ctrl
  import filter_cfg_pkg::*;
#(
  parameter int FILTER_DIM = 3,
  parameter int COE_WIDTH  = 8,
  parameter int NORM_WIDTH = 5,
  parameter int ADDR_WIDTH = $clog2(FILTER_DIM*FILTER_DIM)
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      cfg_wr_valid,
  output logic                                      cfg_wr_ready,
  input  logic [ADDR_WIDTH-1:0]                     cfg_wr_addr,
  input  logic [COE_WIDTH-1:0]                      cfg_wr_data,
  input  logic [NORM_WIDTH-1:0]                     cfg_norm,
  input  logic                                      cfg_commit,
  input  logic                                      cfg_abort,
  input  logic                                      vid_tvalid,
  input  logic                                      vid_tready,
  input  logic                                      vid_tuser,
  output logic [FILTER_DIM*FILTER_DIM*COE_WIDTH-1:0] coef_active,
  output logic [NORM_WIDTH-1:0]                     norm_active,
  output logic                                      cfg_pending,
  output logic                                      swap_pulse,
  output logic                                      err_addr,
  output logic [15:0]                               frame_cnt
);

  localparam int DEPTH  = FILTER_DIM * FILTER_DIM;
  localparam int FLAT_W = DEPTH * COE_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [MAX_FLAT-1:0]   ID_FULL   = identity_kernel(FILTER_DIM, COE_WIDTH);
  localparam logic [FLAT_W-1:0]     ID_FLAT   = ID_FULL[FLAT_W-1:0];

  cfg_state_e            state_q, state_d;
  logic [NORM_WIDTH-1:0] shadow_norm_q, shadow_norm_d;
  logic [NORM_WIDTH-1:0] norm_active_q, norm_active_d;
  logic                  swap_pulse_q, swap_pulse_d;
  logic                  err_addr_q, err_addr_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;

  logic              sof;
  logic              wr_fire;
  logic              swap;
  logic [FLAT_W-1:0] shadow_flat;
  logic [FLAT_W-1:0] shadow_merged;

  always_comb begin
    sof     = vid_tvalid & vid_tready & vid_tuser;
    wr_fire = cfg_wr_valid && (state_q == ST_IDLE);

    state_d       = state_q;
    swap          = 1'b0;
    shadow_norm_d = shadow_norm_q;
    err_addr_d    = err_addr_q;

    case (state_q)
      ST_IDLE: begin
        if (cfg_commit) begin
          shadow_norm_d = cfg_norm;
          err_addr_d    = 1'b0;
          // Commit coinciding with SOF swaps immediately; never arms.
          if (sof) swap = 1'b1;
          else     state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        // Abort has priority over a simultaneous SOF.
        if (cfg_abort) begin
          state_d = ST_IDLE;
        end else if (sof) begin
          swap    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A bad write in the commit cycle still flags, so set wins over clear.
    if (wr_fire && (cfg_wr_addr > LAST_ADDR)) err_addr_d = 1'b1;

    // Shadow contents as of the end of this cycle, so a write accepted in
    // a commit+SOF cycle is part of the set copied into the active bank.
    shadow_merged = shadow_flat;
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_fire && (cfg_wr_addr == ADDR_WIDTH'(i))) begin
        shadow_merged[i*COE_WIDTH +: COE_WIDTH] = cfg_wr_data;
      end
    end

    norm_active_d = swap ? shadow_norm_d : norm_active_q;
    swap_pulse_d  = swap;
    frame_cnt_d   = frame_cnt_q + {15'd0, sof};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      shadow_norm_q <= '0;
      norm_active_q <= '0;
      swap_pulse_q  <= 1'b0;
      err_addr_q    <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      shadow_norm_q <= shadow_norm_d;
      norm_active_q <= norm_active_d;
      swap_pulse_q  <= swap_pulse_d;
      err_addr_q    <= err_addr_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  coef_bank #(
    .DEPTH      (DEPTH),
    .COE_WIDTH  (COE_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .RESET_VAL  (ID_FLAT)
  ) u_shadow (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_fire),
    .wr_addr   (cfg_wr_addr),
    .wr_data   (cfg_wr_data),
    .load_en   (1'b0),
    .load_data ({FLAT_W{1'b0}}),
    .rd_data   (shadow_flat)
  );

  coef_bank #(
    .DEPTH      (DEPTH),
    .COE_WIDTH  (COE_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .RESET_VAL  (ID_FLAT)
  ) u_active (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (1'b0),
    .wr_addr   ({ADDR_WIDTH{1'b0}}),
    .wr_data   ({COE_WIDTH{1'b0}}),
    .load_en   (swap),
    .load_data (shadow_merged),
    .rd_data   (coef_active)
  );

  assign cfg_wr_ready = (state_q == ST_IDLE);
  assign cfg_pending  = (state_q == ST_ARMED);
  assign norm_active  = norm_active_q;
  assign swap_pulse   = swap_pulse_q;
  assign err_addr     = err_addr_q;
  assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_filter_cfg_ctrl.sv
// tb_filter_cfg_ctrl
//   Directed scenarios plus a randomized run for filter_cfg_ctrl (3x3,
//   8-bit coefficients, 5-bit norm), checked against a behavioural model
//   that keeps the shadow/active kernels as plain arrays.
module tb_filter_cfg_ctrl;

  localparam logic [71:0] ID_EXP    = 72'h00_0000_0001_0000_0000;
  localparam logic [71:0] SHARP_EXP = 72'h00_FF00_FF05_FF00_FF00;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        cfg_wr_valid, cfg_wr_ready;
  logic [3:0]  cfg_wr_addr;
  logic [7:0]  cfg_wr_data;
  logic [4:0]  cfg_norm;
  logic        cfg_commit, cfg_abort;
  logic        vid_tvalid, vid_tready, vid_tuser;
  logic [71:0] coef_active;
  logic [4:0]  norm_active;
  logic        cfg_pending, swap_pulse, err_addr;
  logic [15:0] frame_cnt;

  filter_cfg_ctrl #(.FILTER_DIM(3), .COE_WIDTH(8), .NORM_WIDTH(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_wr_valid (cfg_wr_valid),
    .cfg_wr_ready (cfg_wr_ready),
    .cfg_wr_addr  (cfg_wr_addr),
    .cfg_wr_data  (cfg_wr_data),
    .cfg_norm     (cfg_norm),
    .cfg_commit   (cfg_commit),
    .cfg_abort    (cfg_abort),
    .vid_tvalid   (vid_tvalid),
    .vid_tready   (vid_tready),
    .vid_tuser    (vid_tuser),
    .coef_active  (coef_active),
    .norm_active  (norm_active),
    .cfg_pending  (cfg_pending),
    .swap_pulse   (swap_pulse),
    .err_addr     (err_addr),
    .frame_cnt    (frame_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference model
  logic [7:0]  m_shadow [9];
  logic [7:0]  m_active [9];
  logic [4:0]  m_snorm, m_anorm;
  bit          m_armed, m_err, m_swap;
  logic [15:0] m_frames;

  function automatic logic [71:0] pack9(input logic [7:0] a [9]);
    logic [71:0] f;
    for (int i = 0; i < 9; i++) f[i*8 +: 8] = a[i];
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 9; i++) begin
      m_shadow[i] = (i == 4) ? 8'd1 : 8'd0;
      m_active[i] = (i == 4) ? 8'd1 : 8'd0;
    end
    m_snorm = 0; m_anorm = 0; m_armed = 0; m_err = 0; m_swap = 0; m_frames = 0;
  endtask

  // driver tasks
  task automatic clear_inputs();
    cfg_wr_valid = 0; cfg_wr_addr = 0; cfg_wr_data = 0; cfg_norm = 0;
    cfg_commit = 0; cfg_abort = 0; vid_tvalid = 0; vid_tready = 0; vid_tuser = 0;
  endtask

  task automatic drive_sof(input bit en);
    vid_tvalid = en; vid_tready = en; vid_tuser = en;
  endtask

  // Advances the model by the rules for the current inputs, then one clock.
  task automatic tick();
    bit sof, wr, commit_now, sw;
    sof        = vid_tvalid && vid_tready && vid_tuser;
    wr         = cfg_wr_valid && !m_armed;
    commit_now = cfg_commit && !m_armed;
    if (wr && cfg_wr_addr < 9) m_shadow[cfg_wr_addr] = cfg_wr_data;
    if (commit_now) begin m_snorm = cfg_norm; m_err = 0; end
    if (wr && cfg_wr_addr >= 9) m_err = 1;
    sw = sof && (commit_now || (m_armed && !cfg_abort));
    if (sw) begin m_active = m_shadow; m_anorm = m_snorm; end
    if (m_armed) m_armed = !(cfg_abort || sof);
    else         m_armed = cfg_commit && !sof;
    m_swap = sw;
    if (sof) m_frames = m_frames + 16'd1;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    #2 reset = 1;
    model_reset();
    @(posedge clk); #1;
    reset = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    do_reset();
    n_checks++; if (coef_active !== ID_EXP) begin n_fail++; $display("FAIL reset_coef got %h exp %h", coef_active, ID_EXP); end
    n_checks++; if (norm_active !== 5'd0) begin n_fail++; $display("FAIL reset_norm got %0d exp 0", norm_active); end
    n_checks++; if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_frame got %0d exp 0", frame_cnt); end
    n_checks++; if (cfg_wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", cfg_wr_ready); end
    n_checks++; if ({cfg_pending, swap_pulse, err_addr} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b exp 000", {cfg_pending, swap_pulse, err_addr}); end
  endtask

  task automatic test_sharpen();
    logic [7:0] sharp [9];
    int pend_cnt;
    sharp = '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'h05, 8'hFF, 8'h00, 8'hFF, 8'h00};
    for (int i = 0; i < 9; i++) begin
      cfg_wr_valid = 1; cfg_wr_addr = 4'(i); cfg_wr_data = sharp[i];
      tick();
    end
    cfg_wr_valid = 0;
    cfg_commit = 1; cfg_norm = 0;
    tick();
    cfg_commit = 0;
    pend_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (cfg_pending) pend_cnt++;
      n_checks++; if (coef_active !== ID_EXP) begin n_fail++; $display("FAIL sharp_hold cyc %0d got %h exp %h", i, coef_active, ID_EXP); end
      tick();
    end
    drive_sof(1);
    if (cfg_pending) pend_cnt++;
    tick();
    drive_sof(0);
    n_checks++; if (coef_active !== SHARP_EXP) begin n_fail++; $display("FAIL sharp_swap got %h exp %h", coef_active, SHARP_EXP); end
    n_checks++; if (swap_pulse !== 1'b1) begin n_fail++; $display("FAIL sharp_pulse_hi got %b exp 1", swap_pulse); end
    n_checks++; if (cfg_pending !== 1'b0) begin n_fail++; $display("FAIL sharp_pend_fall got %b exp 0", cfg_pending); end
    tick();
    n_checks++; if (swap_pulse !== 1'b0) begin n_fail++; $display("FAIL sharp_pulse_lo got %b exp 0", swap_pulse); end
    n_checks++; if (pend_cnt != 11) begin n_fail++; $display("FAIL sharp_pend_len got %0d exp 11", pend_cnt); end
  endtask

  task automatic test_armed_write();
    cfg_commit = 1; cfg_norm = 5'd3;
    tick();
    cfg_commit = 0;
    cfg_wr_valid = 1; cfg_wr_addr = 4'd2; cfg_wr_data = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (cfg_wr_ready !== 1'b0) begin n_fail++; $display("FAIL armed_ready cyc %0d got %b exp 0", i, cfg_wr_ready); end
      tick();
    end
    drive_sof(1);
    tick();
    drive_sof(0);
    n_checks++; if (coef_active !== SHARP_EXP) begin n_fail++; $display("FAIL armed_swap got %h exp %h", coef_active, SHARP_EXP); end
    n_checks++; if (norm_active !== 5'd3) begin n_fail++; $display("FAIL armed_norm got %0d exp 3", norm_active); end
    n_checks++; if (cfg_wr_ready !== 1'b1) begin n_fail++; $display("FAIL armed_ready_after got %b exp 1", cfg_wr_ready); end
    tick();
    cfg_wr_valid = 0;
    tick();
    n_checks++; if (coef_active !== pack9(m_active)) begin n_fail++; $display("FAIL armed_active_untouched got %h exp %h", coef_active, pack9(m_active)); end
    cfg_commit = 1; drive_sof(1);
    tick();
    cfg_commit = 0; drive_sof(0);
    n_checks++; if (coef_active[23:16] !== 8'h5A) begin n_fail++; $display("FAIL armed_write_in_shadow got %h exp 5a", coef_active[23:16]); end
  endtask

  task automatic test_commit_sof_same();
    cfg_wr_valid = 1; cfg_wr_addr = 4'd4; cfg_wr_data = 8'd9;
    cfg_commit = 1; cfg_norm = 5'd7; drive_sof(1);
    tick();
    clear_inputs();
    n_checks++; if (coef_active[39:32] !== 8'd9) begin n_fail++; $display("FAIL same_idx4 got %0d exp 9", coef_active[39:32]); end
    n_checks++; if (coef_active !== pack9(m_active)) begin n_fail++; $display("FAIL same_coef got %h exp %h", coef_active, pack9(m_active)); end
    n_checks++; if (cfg_pending !== 1'b0) begin n_fail++; $display("FAIL same_pend got %b exp 0", cfg_pending); end
    n_checks++; if (norm_active !== 5'd7) begin n_fail++; $display("FAIL same_norm got %0d exp 7", norm_active); end
    n_checks++; if (swap_pulse !== 1'b1) begin n_fail++; $display("FAIL same_pulse got %b exp 1", swap_pulse); end
  endtask

  task automatic test_err_addr();
    logic [71:0] snap;
    snap = pack9(m_shadow);
    cfg_wr_valid = 1; cfg_wr_addr = 4'd9; cfg_wr_data = 8'hEE;
    tick();
    cfg_wr_valid = 0;
    n_checks++; if (err_addr !== 1'b1) begin n_fail++; $display("FAIL err_set got %b exp 1", err_addr); end
    tick();
    n_checks++; if (err_addr !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %b exp 1", err_addr); end
    cfg_commit = 1; drive_sof(1);
    tick();
    cfg_commit = 0; drive_sof(0);
    n_checks++; if (coef_active !== snap) begin n_fail++; $display("FAIL err_shadow got %h exp %h", coef_active, snap); end
    n_checks++; if (err_addr !== 1'b0) begin n_fail++; $display("FAIL err_clear got %b exp 0", err_addr); end
  endtask

  task automatic test_abort_and_reset();
    logic [71:0] prior;
    logic [15:0] f0;
    prior = pack9(m_active);
    f0 = m_frames;
    cfg_wr_valid = 1; cfg_wr_addr = 4'd0; cfg_wr_data = 8'h33;
    tick();
    cfg_wr_valid = 0; cfg_commit = 1;
    tick();
    cfg_commit = 0;
    tick();
    cfg_abort = 1; drive_sof(1);
    tick();
    cfg_abort = 0;
    n_checks++; if (swap_pulse !== 1'b0) begin n_fail++; $display("FAIL abort_pulse got %b exp 0", swap_pulse); end
    n_checks++; if (coef_active !== prior) begin n_fail++; $display("FAIL abort_coef got %h exp %h", coef_active, prior); end
    n_checks++; if (frame_cnt !== f0 + 16'd1) begin n_fail++; $display("FAIL abort_frame got %0d exp %0d", frame_cnt, f0 + 16'd1); end
    tick();
    drive_sof(0);
    n_checks++; if (swap_pulse !== 1'b0 || coef_active !== prior) begin n_fail++; $display("FAIL abort_idle_sof got pulse %b coef %h exp 0 %h", swap_pulse, coef_active, prior); end
    n_checks++; if (frame_cnt !== f0 + 16'd2) begin n_fail++; $display("FAIL abort_frame2 got %0d exp %0d", frame_cnt, f0 + 16'd2); end
    cfg_commit = 1;
    tick();
    cfg_commit = 0;
    n_checks++; if (cfg_pending !== 1'b1) begin n_fail++; $display("FAIL rst_armed_pend got %b exp 1", cfg_pending); end
    do_reset();
    drive_sof(1);
    tick();
    drive_sof(0);
    tick();
    n_checks++; if (coef_active !== ID_EXP) begin n_fail++; $display("FAIL rst_armed_coef got %h exp %h", coef_active, ID_EXP); end
    n_checks++; if (swap_pulse !== 1'b0 || cfg_pending !== 1'b0) begin n_fail++; $display("FAIL rst_armed_flags got %b%b exp 00", swap_pulse, cfg_pending); end
    n_checks++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL rst_armed_frame got %0d exp 1", frame_cnt); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cfg_wr_valid = 1'($urandom_range(0, 1));
      cfg_wr_addr  = 4'($urandom_range(0, 10));
      cfg_wr_data  = 8'($urandom);
      cfg_norm     = 5'($urandom);
      cfg_commit   = ($urandom_range(0, 7) == 0);
      cfg_abort    = ($urandom_range(0, 15) == 0);
      vid_tvalid   = 1'($urandom_range(0, 1));
      vid_tready   = 1'($urandom_range(0, 1));
      vid_tuser    = ($urandom_range(0, 3) == 0);
      n_checks++; if (cfg_wr_ready !== !m_armed) begin n_fail++; $display("FAIL rnd_ready cyc %0d got %b exp %b", i, cfg_wr_ready, !m_armed); end
      tick();
      n_checks++;
      if (coef_active !== pack9(m_active) || norm_active !== m_anorm || cfg_pending !== m_armed ||
          swap_pulse !== m_swap || err_addr !== m_err || frame_cnt !== m_frames) begin
        n_fail++;
        $display("FAIL rnd_out cyc %0d got coef %h norm %0d pend %b pulse %b err %b frame %0d exp coef %h norm %0d pend %b pulse %b err %b frame %0d",
                 i, coef_active, norm_active, cfg_pending, swap_pulse, err_addr, frame_cnt,
                 pack9(m_active), m_anorm, m_armed, m_swap, m_err, m_frames);
      end
    end
    clear_inputs();
  endtask

  initial begin
    reset = 0;
    clear_inputs();
    model_reset();
    test_reset();
    test_sharpen();
    test_armed_write();
    test_commit_sof_same();
    test_err_addr();
    test_abort_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
